aud_ctrl: RTL

Mode controller for the audio record/playback path. It turns debounced user key pulses into single-cycle start/pause/stop commands for the recorder and the player, and tracks the recorded length for playback. It also keeps an elapsed-seconds counter for the display. It sits between the key/debounce logic and the recorder and player blocks, all in one clock domain.

---
 rtl/aud_ctrl.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/aud_ctrl.sv
// aud_ctrl: record/playback mode controller.
// Turns debounced key pulses into single-cycle recorder/player commands,
// remembers where the last complete recording ended and keeps an
// elapsed-seconds counter for the display.
module aud_ctrl #(
   parameter int unsigned CLK_HZ      = 12000000,
   parameter int unsigned MAX_SEC     = 255,
   parameter int unsigned TIMEOUT_CYC = 1024
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_key_rec,
   input  logic        i_key_play,
   input  logic        i_key_pause,
   input  logic        i_key_stop,
   input  logic        i_rec_done,
   input  logic [19:0] i_rec_addr,
   input  logic        i_play_done,
   output logic        o_rec_start,
   output logic        o_rec_pause,
   output logic        o_rec_stop,
   output logic        o_play_start,
   output logic        o_play_pause,
   output logic        o_play_stop,
   output logic [19:0] o_play_end,
   output logic        o_has_data,
   output logic [2:0]  o_state,
   output logic [7:0]  o_sec,
   output logic        o_err
);

   localparam int unsigned TICK_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam int unsigned WAIT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLK_HZ - 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYC - 1);
   localparam logic [7:0]        SEC_MAX   = 8'(MAX_SEC);

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      REC        = 3'd1,
      REC_PAUSE  = 3'd2,
      REC_WAIT   = 3'd3,
      PLAY       = 3'd4,
      PLAY_PAUSE = 3'd5,
      PLAY_WAIT  = 3'd6
   } state_t;

   state_t            state_q;
   state_t            state_d;
   logic              rec_done_q;
   logic              play_done_q;
   logic              rec_rise;
   logic              play_rise;
   logic [TICK_W-1:0] tick_cnt;
   logic [WAIT_W-1:0] wait_cnt;
   logic              rec_start_d;
   logic              rec_pause_d;
   logic              rec_stop_d;
   logic              play_start_d;
   logic              play_pause_d;
   logic              play_stop_d;
   logic              err_d;
   logic              latch_d;
   logic              sec_clr_d;

   // Done is high while a sub-block is idle, so only its rising edge means "finished"
   assign rec_rise  = i_rec_done & ~rec_done_q;
   assign play_rise = i_play_done & ~play_done_q;
   assign o_state   = state_q;

   // Next-state and command decode; keys that a state does not react to are simply dropped
   always_comb begin
      state_d      = state_q;
      rec_start_d  = 1'b0;
      rec_pause_d  = 1'b0;
      rec_stop_d   = 1'b0;
      play_start_d = 1'b0;
      play_pause_d = 1'b0;
      play_stop_d  = 1'b0;
      err_d        = 1'b0;
      latch_d      = 1'b0;
      sec_clr_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (i_key_rec) begin
               rec_start_d = 1'b1;
               sec_clr_d   = 1'b1;
               state_d     = REC;
            end else if (i_key_play && o_has_data) begin
               play_start_d = 1'b1;
               sec_clr_d    = 1'b1;
               state_d      = PLAY;
            end
         end
         REC: begin
            if (i_key_stop) begin
               rec_stop_d = 1'b1;
               state_d    = REC_WAIT;
            end else if (i_key_pause) begin
               rec_pause_d = 1'b1;
               state_d     = REC_PAUSE;
            end else if (rec_rise) begin
               latch_d = 1'b1;
               state_d = IDLE;
            end
         end
         REC_PAUSE: begin
            if (i_key_stop) begin
               rec_stop_d = 1'b1;
               state_d    = REC_WAIT;
            end else if (i_key_rec) begin
               rec_start_d = 1'b1;
               state_d     = REC;
            end
         end
         REC_WAIT: begin
            if (rec_rise) begin
               latch_d = 1'b1;
               state_d = IDLE;
            end else if (wait_cnt == WAIT_LAST) begin
               err_d   = 1'b1;
               state_d = IDLE;
            end
         end
         PLAY: begin
            if (i_key_stop) begin
               play_stop_d = 1'b1;
               state_d     = PLAY_WAIT;
            end else if (i_key_pause) begin
               play_pause_d = 1'b1;
               state_d      = PLAY_PAUSE;
            end else if (play_rise) begin
               state_d = IDLE;
            end
         end
         PLAY_PAUSE: begin
            if (i_key_stop) begin
               play_stop_d = 1'b1;
               state_d     = PLAY_WAIT;
            end else if (i_key_play) begin
               play_start_d = 1'b1;
               state_d      = PLAY;
            end
         end
         PLAY_WAIT: begin
            if (play_rise) begin
               state_d = IDLE;
            end else if (wait_cnt == WAIT_LAST) begin
               err_d   = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State register, registered command pulses and done-edge history
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q      <= IDLE;
         o_rec_start  <= 1'b0;
         o_rec_pause  <= 1'b0;
         o_rec_stop   <= 1'b0;
         o_play_start <= 1'b0;
         o_play_pause <= 1'b0;
         o_play_stop  <= 1'b0;
         o_err        <= 1'b0;
         rec_done_q   <= 1'b0;
         play_done_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         o_rec_start  <= rec_start_d;
         o_rec_pause  <= rec_pause_d;
         o_rec_stop   <= rec_stop_d;
         o_play_start <= play_start_d;
         o_play_pause <= play_pause_d;
         o_play_stop  <= play_stop_d;
         o_err        <= err_d;
         rec_done_q   <= i_rec_done;
         play_done_q  <= i_play_done;
      end
   end

   // Wait-state timeout counter, zero whenever we are outside a wait state
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wait_cnt <= '0;
      end else if (state_q == REC_WAIT || state_q == PLAY_WAIT) begin
         wait_cnt <= wait_cnt + 1'b1;
      end else begin
         wait_cnt <= '0;
      end
   end

   // Elapsed time: ticks only while actively recording or playing, seconds saturate
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         tick_cnt <= '0;
         o_sec    <= 8'd0;
      end else if (sec_clr_d) begin
         tick_cnt <= '0;
         o_sec    <= 8'd0;
      end else if (state_q == IDLE) begin
         tick_cnt <= '0;
      end else if (state_q == REC || state_q == PLAY) begin
         if (tick_cnt == TICK_LAST) begin
            tick_cnt <= '0;
            if (o_sec != SEC_MAX) begin
               o_sec <= o_sec + 8'd1;
            end
         end else begin
            tick_cnt <= tick_cnt + 1'b1;
         end
      end
   end

   // Capture the end of a recording only when the recorder really finished
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_play_end <= 20'd0;
         o_has_data <= 1'b0;
      end else if (latch_d) begin
         o_play_end <= i_rec_addr;
         o_has_data <= 1'b1;
      end
   end

endmodule
